// File: rtl/mem_handle_responder.sv
// rtl/mem_handle_responder.sv - mem_handle responder: round-robin access to one word memory
// Optional MEM_RESP_PERF_EN adds saturating perf_rd/perf_wr/perf_wait counters.
module mem_handle_responder #(
   parameter int N_HANDLES = 4,
   parameter int ADDR_W    = 16,
   parameter int DEPTH     = 4096,
   localparam int IDX_W    = (N_HANDLES > 1) ? $clog2(N_HANDLES) : 1
) (
   input  logic                          clk,
   input  logic                          rst_l,
   input  logic [N_HANDLES-1:0]          avail,
   input  logic [N_HANDLES-1:0]          r_en,
   input  logic [N_HANDLES-1:0]          w_en,
   input  logic [N_HANDLES*ADDR_W-1:0]   ptr,
   input  logic [N_HANDLES*32-1:0]       data_store,
   output logic [N_HANDLES*32-1:0]       data_load,
   output logic [N_HANDLES-1:0]          done,
   output logic [N_HANDLES*ADDR_W-1:0]   region_begin,
   input  logic                          cfg_we,
   input  logic [IDX_W-1:0]              cfg_idx,
   input  logic [ADDR_W-1:0]             cfg_base,
`ifdef MEM_RESP_PERF_EN
   output logic [31:0]                   perf_rd,
   output logic [31:0]                   perf_wr,
   output logic [31:0]                   perf_wait,
`endif
   output logic                          err
);

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t                state_q;
   logic [IDX_W-1:0]      rr_q;
   logic [IDX_W-1:0]      idx_q;
   logic                  rd_q;
   logic                  wr_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [31:0]           wdata_q;
   logic [N_HANDLES-1:0]  done_q;
   logic [31:0]           load_q [N_HANDLES];
   logic [ADDR_W-1:0]     base_q [N_HANDLES];
   logic                  err_q;

   logic [31:0]           mem [DEPTH];

   logic [IDX_W-1:0]      grant_d;
   logic                  grant_vld_d;
   logic                  in_range;
   logic                  bad_op;
   logic [MEM_AW-1:0]     mem_addr;

   // First requesting handle at or after the round-robin pointer, wrapping.
   always_comb begin
      grant_vld_d = 1'b0;
      grant_d     = '0;
      for (int k = 0; k < N_HANDLES; k++) begin
         if (!grant_vld_d && avail[(int'(rr_q) + k) % N_HANDLES]) begin
            grant_vld_d = 1'b1;
            grant_d     = IDX_W'((int'(rr_q) + k) % N_HANDLES);
         end
      end
   end

   assign in_range = ({1'b0, addr_q} < DEPTH_W);
   assign bad_op   = (rd_q == wr_q);
   assign mem_addr = addr_q[MEM_AW-1:0];

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         idx_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < N_HANDLES; i++) begin
            load_q[i] <= '0;
            base_q[i] <= ADDR_W'(i * (DEPTH / N_HANDLES));
         end
      end else begin
         if (cfg_we && (int'(cfg_idx) < N_HANDLES))
            base_q[cfg_idx] <= cfg_base;
         case (state_q)
            S_IDLE: begin
               if (grant_vld_d) begin
                  idx_q   <= grant_d;
                  rd_q    <= r_en[grant_d];
                  wr_q    <= w_en[grant_d];
                  addr_q  <= ptr[int'(grant_d) * ADDR_W +: ADDR_W];
                  wdata_q <= data_store[int'(grant_d) * 32 +: 32];
                  state_q <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               done_q[idx_q] <= 1'b1;
               if (rd_q && !wr_q)
                  load_q[idx_q] <= in_range ? mem[mem_addr] : 32'h0;
               if (bad_op || !in_range)
                  err_q <= 1'b1;
               rr_q    <= (idx_q == IDX_W'(N_HANDLES - 1)) ? '0 : idx_q + IDX_W'(1);
               state_q <= S_RESP;
            end
            S_RESP: begin
               done_q  <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Commit happens only on the edge that ends ACCESS, so an earlier reset drops it.
   always_ff @(posedge clk) begin
      if (state_q == S_ACCESS && wr_q && in_range)
         mem[mem_addr] <= wdata_q;
   end

   for (genvar g = 0; g < N_HANDLES; g++) begin : g_out
      assign data_load[g*32 +: 32]             = load_q[g];
      assign region_begin[g*ADDR_W +: ADDR_W]  = base_q[g];
   end

   assign done = done_q;
   assign err  = err_q;

`ifdef MEM_RESP_PERF_EN
   logic [31:0]          perf_rd_q;
   logic [31:0]          perf_wr_q;
   logic [31:0]          perf_wait_q;
   logic [N_HANDLES-1:0] serviced;

   always_comb begin
      serviced = '0;
      if (state_q == S_IDLE) begin
         if (grant_vld_d)
            serviced[grant_d] = 1'b1;
      end else begin
         serviced[idx_q] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         perf_rd_q   <= '0;
         perf_wr_q   <= '0;
         perf_wait_q <= '0;
      end else begin
         if (state_q == S_ACCESS && rd_q && !wr_q && perf_rd_q != '1)
            perf_rd_q <= perf_rd_q + 32'd1;
         if (state_q == S_ACCESS && wr_q && perf_wr_q != '1)
            perf_wr_q <= perf_wr_q + 32'd1;
         if (|(avail & ~serviced) && perf_wait_q != '1)
            perf_wait_q <= perf_wait_q + 32'd1;
      end
   end

   assign perf_rd   = perf_rd_q;
   assign perf_wr   = perf_wr_q;
   assign perf_wait = perf_wait_q;
`endif

endmodule

// File: tb/tb_mem_handle_responder.sv
// tb/tb_mem_handle_responder.sv - scoreboard bench for mem_handle_responder
module tb_mem_handle_responder;

   localparam int N     = 4;
   localparam int AW    = 16;
   localparam int DEPTH = 4096;

   logic            clk;
   logic            rst_l;
   logic [N-1:0]    avail;
   logic [N-1:0]    r_en;
   logic [N-1:0]    w_en;
   logic [N*AW-1:0] ptr;
   logic [N*32-1:0] data_store;
   logic [N*32-1:0] data_load;
   logic [N-1:0]    done;
   logic [N*AW-1:0] region_begin;
   logic            cfg_we;
   logic [1:0]      cfg_idx;
   logic [AW-1:0]   cfg_base;
   logic            err;

   int vectors;
   int miscompares;

   typedef struct {
      int          h;
      bit          rd;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [int];

   mem_handle_responder #(.N_HANDLES(N), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .avail        (avail),
      .r_en         (r_en),
      .w_en         (w_en),
      .ptr          (ptr),
      .data_store   (data_store),
      .data_load    (data_load),
      .done         (done),
      .region_begin (region_begin),
      .cfg_we       (cfg_we),
      .cfg_idx      (cfg_idx),
      .cfg_base     (cfg_base),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_l) begin
         for (int h = 0; h < N; h++) begin
            if (done[h]) begin
               exp_t e;
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL sb_unexpected_done: done[%0d] seen, none expected", h);
               end else begin
                  e = sb.pop_front();
                  if (e.h !== h || (e.rd && data_load[h*32 +: 32] !== e.data)) begin
                     miscompares++;
                     $display("FAIL sb_resp: got handle %0d data 0x%08h, want handle %0d data 0x%08h",
                              h, data_load[h*32 +: 32], e.h, e.data);
                  end
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] model_rd(input int p);
      if (p < DEPTH && model.exists(p)) return model[p];
      return 32'h0;
   endfunction

   task automatic do_reset();
      rst_l = 1'b0;
      avail = '0; r_en = '0; w_en = '0; ptr = '0; data_store = '0;
      cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0;
      repeat (2) @(posedge clk);
      #3 rst_l = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic issue(input int h, input bit r, input bit w, input int p,
                        input logic [31:0] d, output int lat);
      exp_t e;
      e.h = h; e.rd = r && !w; e.data = e.rd ? model_rd(p) : 32'h0;
      sb.push_back(e);
      if (w && p < DEPTH) model[p] = d;
      r_en[h] = r; w_en[h] = w;
      ptr[h*AW +: AW] = AW'(p);
      data_store[h*32 +: 32] = d;
      avail[h] = 1'b1;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!done[h] && lat < 20);
      if (!done[h]) begin
         vectors++; miscompares++;
         $display("FAIL issue_timeout: handle %0d no done after %0d cycles", h, lat);
      end
      avail[h] = 1'b0; r_en[h] = 1'b0; w_en[h] = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (done !== 4'h0) begin miscompares++; $display("FAIL rst_done: got %h want 0", done); end
      vectors++;
      if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
      vectors++;
      if (data_load !== '0) begin miscompares++; $display("FAIL rst_data_load: got %h want 0", data_load); end
      for (int i = 0; i < N; i++) begin
         vectors++;
         if (region_begin[i*AW +: AW] !== AW'(i * (DEPTH / N))) begin
            miscompares++;
            $display("FAIL rst_region_begin[%0d]: got 0x%h want 0x%h", i, region_begin[i*AW +: AW], i * (DEPTH / N));
         end
      end
   endtask

   task automatic test_write_read();
      int lat;
      issue(3, 1'b0, 1'b1, 5, 32'h1, lat);
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL wr_latency: got %0d want 2", lat); end
      vectors++;
      if (data_load[3*32 +: 32] !== 32'h0) begin
         miscompares++; $display("FAIL wr_keeps_load: got 0x%h want 0", data_load[3*32 +: 32]);
      end
      issue(3, 1'b1, 1'b0, 5, 32'h0, lat);
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL rd_latency: got %0d want 2", lat); end
      vectors++;
      if (data_load[3*32 +: 32] !== 32'h1) begin
         miscompares++; $display("FAIL rd_hold: got 0x%h want 0x1", data_load[3*32 +: 32]);
      end
   endtask

   task automatic test_contention(input int first, input int second, input logic [31:0] base_val);
      int   order[$];
      int   cyc;
      exp_t e;
      e.rd = 1'b0; e.data = 32'h0;
      e.h = first;  sb.push_back(e);
      e.h = second; sb.push_back(e);
      for (int k = 0; k < 2; k++) begin
         int h;
         h = (k == 0) ? 0 : 2;
         w_en[h] = 1'b1;
         ptr[h*AW +: AW] = AW'(20 + h);
         data_store[h*32 +: 32] = base_val + 32'(h);
         model[20 + h] = base_val + 32'(h);
         avail[h] = 1'b1;
      end
      cyc = 0;
      while ((avail[0] || avail[2]) && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
         for (int h = 0; h < N; h += 2) begin
            if (done[h] && avail[h]) begin
               order.push_back(h);
               avail[h] = 1'b0; w_en[h] = 1'b0;
            end
         end
      end
      avail = '0; w_en = '0;
      @(posedge clk); #1;
      vectors++;
      if (order.size() != 2 || order[0] != first || order[1] != second) begin
         miscompares++;
         $display("FAIL contention_order: got %0d grants, first %0d, want %0d then %0d",
                  order.size(), (order.size() > 0) ? order[0] : -1, first, second);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int pulses;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         issue(1, 1'b0, 1'b1, 100 + i, 32'h10 + 32'(i), lat);
         if (lat <= 2) pulses++;
      end
      vectors++;
      if (pulses !== 4) begin miscompares++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
      vectors++;
      if (data_load[1*32 +: 32] !== 32'h0) begin
         miscompares++; $display("FAIL b2b_load_unchanged: got 0x%h want 0", data_load[1*32 +: 32]);
      end
      for (int i = 0; i < 4; i++) issue(1, 1'b1, 1'b0, 100 + i, 32'h0, lat);
   endtask

   task automatic test_out_of_range();
      int lat;
      vectors++;
      if (err !== 1'b0) begin miscompares++; $display("FAIL oor_err_before: got %b want 0", err); end
      issue(2, 1'b0, 1'b1, 0, 32'h1234, lat);
      issue(2, 1'b0, 1'b1, DEPTH, 32'hDEAD, lat);
      issue(2, 1'b1, 1'b0, DEPTH, 32'h0, lat);
      vectors++;
      if (err !== 1'b1) begin miscompares++; $display("FAIL oor_err_set: got %b want 1", err); end
      issue(2, 1'b1, 1'b0, 0, 32'h0, lat);
      vectors++;
      if (err !== 1'b1) begin miscompares++; $display("FAIL oor_err_sticky: got %b want 1", err); end
   endtask

   task automatic test_conflict();
      int lat;
      do_reset();
      issue(0, 1'b1, 1'b1, 9, 32'h99, lat);
      vectors++;
      if (err !== 1'b1) begin miscompares++; $display("FAIL conflict_err: got %b want 1", err); end
      do_reset();
      issue(0, 1'b0, 1'b0, 9, 32'h77, lat);
      vectors++;
      if (err !== 1'b1) begin miscompares++; $display("FAIL noop_err: got %b want 1", err); end
      issue(0, 1'b1, 1'b0, 9, 32'h0, lat);
   endtask

   task automatic test_config();
      cfg_we = 1'b1; cfg_idx = 2'd2; cfg_base = 16'h0200;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      vectors++;
      if (region_begin[2*AW +: AW] !== 16'h0200) begin
         miscompares++; $display("FAIL cfg_write: got 0x%h want 0x0200", region_begin[2*AW +: AW]);
      end
      vectors++;
      if (region_begin[1*AW +: AW] !== 16'(DEPTH / N)) begin
         miscompares++; $display("FAIL cfg_other: got 0x%h want 0x%h", region_begin[1*AW +: AW], DEPTH / N);
      end
      do_reset();
      vectors++;
      if (region_begin[2*AW +: AW] !== 16'(2 * DEPTH / N)) begin
         miscompares++; $display("FAIL cfg_reset: got 0x%h want 0x%h", region_begin[2*AW +: AW], 2 * DEPTH / N);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      issue(0, 1'b0, 1'b1, 7, 32'hAA, lat);
      w_en[0] = 1'b1; ptr[0 +: AW] = 16'd7; data_store[0 +: 32] = 32'h55; avail[0] = 1'b1;
      @(posedge clk); #3;
      rst_l = 1'b0;
      avail = '0; w_en = '0;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (done !== 4'h0) begin miscompares++; $display("FAIL abort_done[%0d]: got %h want 0", c, done); end
         @(posedge clk); #1;
      end
      rst_l = 1'b1;
      @(posedge clk); #1;
      issue(0, 1'b1, 1'b0, 7, 32'h0, lat);
      vectors++;
      if (lat !== 2) begin miscompares++; $display("FAIL abort_idle_latency: got %0d want 2", lat); end
   endtask

   initial begin
      int lat;
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_write_read();
      test_contention(0, 2, 32'hA000);
      issue(0, 1'b0, 1'b1, 30, 32'h3030, lat);
      test_contention(2, 0, 32'hB000);
      test_back_to_back();
      test_out_of_range();
      test_conflict();
      test_config();
      test_reset_mid();
      repeat (3) @(posedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++; $display("FAIL sb_drain: %0d responses outstanding, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
